// File: rtl/pwrite_pkg.sv
`default_nettype none
// ============================================================================
// pwrite_pkg : shared FSM state, LFSR constants and helpers for pwrite_engine
// Revision   : 1.0
// ============================================================================
package pwrite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CALC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
  localparam logic [31:0] STAT_MAX    = 32'hFFFF_FFFF;
  localparam logic [31:0] SEED_STRIDE = 32'h9E37_79B9;

  // Per-instance seed; an all-zero LFSR would lock up, so it is nudged to 1.
  function automatic logic [31:0] lfsr_seed(input logic [31:0] seed, input int unsigned k);
    logic [31:0] s;
    s = seed ^ (k * SEED_STRIDE);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pw_rng.sv
`default_nettype none
// ============================================================================
// pw_rng   : bank of 32-bit Galois LFSRs forming a wide random vector
// Revision : 1.0
// ============================================================================
module pw_rng
  import pwrite_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          PROB_WIDTH = 8,
  parameter logic [31:0] SEED       = 32'hACE1_2024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             adv,
  output logic [DATA_WIDTH*PROB_WIDTH-1:0] rnd
);

  localparam int NUM_LFSR = (DATA_WIDTH * PROB_WIDTH) / 32;

  generate
    for (genvar k = 0; k < NUM_LFSR; k++) begin : g_lfsr
      logic [31:0] lfsr_q;
      logic [31:0] lfsr_d;

      always_comb begin
        lfsr_d = lfsr_q;
        if (adv) lfsr_d = lfsr_step(lfsr_q);
      end

      always_ff @(posedge clk) begin
        if (reset) lfsr_q <= lfsr_seed(SEED, k);
        else       lfsr_q <= lfsr_d;
      end

      assign rnd[k*32 +: 32] = lfsr_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pwrite_engine.sv
`default_nettype none
// ============================================================================
// pwrite_engine : probabilistic read-modify-write engine for a 1-cycle RAM
// Revision      : 1.0
// ============================================================================
module pwrite_engine
  import pwrite_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 32,
  parameter int          PROB_WIDTH = 8,
  parameter logic [31:0] SEED       = 32'hACE1_2024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [ADDR_WIDTH-1:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]              req_data,
  input  logic [DATA_WIDTH-1:0]              req_mask,
  input  logic                               req_bypass,
  input  logic [PROB_WIDTH:0]                p_set,
  input  logic [PROB_WIDTH:0]                p_clr,
  output logic                               mem_en,
  output logic [DATA_WIDTH/8-1:0]            mem_we,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_din,
  input  logic [DATA_WIDTH-1:0]              mem_dout,
  output logic                               done_valid,
  output logic [$clog2(DATA_WIDTH+1)-1:0]    done_flips,
  input  logic                               stat_clear,
  output logic [31:0]                        stat_flips
);

  localparam int FLIP_W = $clog2(DATA_WIDTH + 1);
  localparam int RND_W  = DATA_WIDTH * PROB_WIDTH;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [PROB_WIDTH:0]     p_set_q, p_set_d;
  logic [PROB_WIDTH:0]     p_clr_q, p_clr_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [FLIP_W-1:0]       flips_q, flips_d;
  logic [31:0]             stat_q, stat_d;

  logic [RND_W-1:0]        rnd;
  logic                    rng_adv;
  logic [DATA_WIDTH-1:0]   new_word;
  logic [FLIP_W-1:0]       new_flips;
  logic [PROB_WIDTH:0]     rnd_bit;
  logic [32:0]             stat_sum;

  pw_rng #(
    .DATA_WIDTH (DATA_WIDTH),
    .PROB_WIDTH (PROB_WIDTH),
    .SEED       (SEED)
  ) u_rng (
    .clk   (clk),
    .reset (reset),
    .adv   (rng_adv),
    .rnd   (rnd)
  );

  // A bit moves toward its target only when eligible, different, and the dice allow.
  always_comb begin
    new_word  = mem_dout;
    new_flips = '0;
    rnd_bit   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rnd_bit = {1'b0, rnd[i*PROB_WIDTH +: PROB_WIDTH]};
      if (mask_q[i] && (data_q[i] != mem_dout[i]) &&
          (data_q[i] ? (rnd_bit < p_set_q) : (rnd_bit < p_clr_q))) begin
        new_word[i] = data_q[i];
        new_flips   = new_flips + FLIP_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    p_set_d = p_set_q;
    p_clr_d = p_clr_q;
    word_d  = word_q;
    flips_d = flips_q;
    rng_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          mask_d  = req_mask;
          p_set_d = p_set;
          p_clr_d = p_clr;
          if (req_bypass) begin
            word_d  = req_data;
            flips_d = '0;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = ST_CALC;
      ST_CALC: begin
        word_d  = new_word;
        flips_d = new_flips;
        rng_adv = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clear takes priority over accumulation; the sum saturates instead of wrapping.
  always_comb begin
    stat_d   = stat_q;
    stat_sum = '0;
    if (stat_clear) begin
      stat_d = '0;
    end else if (done_valid) begin
      stat_sum = {1'b0, stat_q} + 33'(done_flips);
      stat_d   = stat_sum[32] ? STAT_MAX : stat_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      p_set_q <= '0;
      p_clr_q <= '0;
      word_q  <= '0;
      flips_q <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      p_set_q <= p_set_d;
      p_clr_q <= p_clr_d;
      word_q  <= word_d;
      flips_q <= flips_d;
      stat_q  <= stat_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_en     = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign mem_we     = (state_q == ST_WRITE) ? '1 : '0;
  assign mem_addr   = addr_q;
  assign mem_din    = word_q;
  assign done_valid = (state_q == ST_WRITE);
  assign done_flips = (state_q == ST_WRITE) ? flips_q : '0;
  assign stat_flips = stat_q;

endmodule
`default_nettype wire

// File: doc/pwrite_engine.md
PWRITE_ENGINE -- requirements
Module: pwrite_engine

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, word address width of the attached RAM port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, RAM word width; multiple of 8.
REQ-003 The block SHALL have parameter PROB_WIDTH, default 8, random/probability comparison width; DATA_WIDTH*PROB_WIDTH multiple of 32.
REQ-004 The block SHALL have parameter SEED, default 32'hACE1_2024, RNG seed; non-zero.
REQ-005 The block SHALL have one clock and one reset; the reset is synchronous and active-high. Ports: clk  in  1  sole clock, all logic on rising edge; reset  in  1  synchronous active-high reset.
REQ-006 The block SHALL have port req_valid  in  1  write request.
REQ-007 The block SHALL have port req_ready  out  1  engine idle, request accepted on valid&ready.
REQ-008 The block SHALL have port req_addr  in  ADDR_WIDTH  word address.
REQ-009 The block SHALL have port req_data  in  DATA_WIDTH  target word.
REQ-010 The block SHALL have port req_mask  in  DATA_WIDTH  bits eligible for change.
REQ-011 The block SHALL have port req_bypass  in  1  deterministic direct write.
REQ-012 The block SHALL have ports p_set and p_clr  in  PROB_WIDTH+1  each: probability of a 0->1 / 1->0 transition, scaled by 2^PROB_WIDTH.
REQ-013 The block SHALL have RAM port mem_en  out  1, mem_we  out  DATA_WIDTH/8, mem_addr  out  ADDR_WIDTH, mem_din  out  DATA_WIDTH, mem_dout  in  DATA_WIDTH; the RAM has 1-cycle read latency.
REQ-014 The block SHALL have port done_valid  out  1  one-cycle completion pulse.
REQ-015 The block SHALL have port done_flips  out  $clog2(DATA_WIDTH+1)  bits changed by the completed op.
REQ-016 The block SHALL have ports stat_clear  in  1 and stat_flips  out  32: saturating cumulative flip count.

Function
REQ-017 The FSM SHALL have states IDLE, READ, CALC, WRITE; req_ready=1 only in IDLE.
REQ-018 On acceptance the engine SHALL capture req_addr, req_data, req_mask, req_bypass, p_set and p_clr; later input changes SHALL NOT affect the op.
REQ-019 Non-bypass sequencing: accept at edge T; READ at T+1 drives mem_en=1, mem_we=0, mem_addr; CALC at T+2 samples mem_dout and registers the new word; WRITE at T+3 drives mem_en=1, mem_we all ones, mem_din=new word, done_valid=1; IDLE at T+4.
REQ-020 Bypass sequencing: IDLE->WRITE at T+1 with mem_din=req_data, mem_we all ones, done_valid=1 and done_flips=0; IDLE at T+2.
REQ-021 New-word rule: bit i changes iff req_mask[i]=1, req_data[i]!=old[i], and rnd_i < p_set (target 1) or rnd_i < p_clr (target 0); otherwise new[i]=old[i].
REQ-022 rnd_i SHALL be bits [i*PROB_WIDTH +: PROB_WIDTH] of the RNG vector as an unsigned value; p=0 never changes a bit, and p>=2^PROB_WIDTH always changes it.
REQ-023 The RNG SHALL advance exactly once per CALC cycle and hold in all other states.
REQ-024 done_flips SHALL equal popcount(new ^ old) and be valid only while done_valid=1; otherwise 0.
REQ-025 stat_flips SHALL add done_flips on each done_valid and saturate at 32'hFFFF_FFFF.
REQ-026 stat_clear SHALL zero stat_flips on the next edge; when coincident with done_valid, the clear wins and that op's flips are discarded.
REQ-027 A request with req_mask=0 SHALL still perform read and write of the unchanged word, with done_flips=0.
REQ-028 In non-IDLE states req_valid SHALL be ignored; no queuing.
REQ-029 Outside READ/WRITE, mem_en=0 and mem_we=0.

Reset
REQ-030 On reset: state=IDLE, req_ready=1, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, done_valid=0, done_flips=0, stat_flips=0, RNG=seed.
REQ-031 Reset asserted mid-op SHALL abort the op: no write is issued after the reset edge, and there is no done pulse.

Structure
REQ-032 A shared package pwrite_pkg SHALL hold the FSM state enum, the LFSR tap constant 32'h8020_0003 and the saturating-counter max.
REQ-033 The RNG SHALL be one sub-module, pw_rng, made of (DATA_WIDTH*PROB_WIDTH)/32 32-bit Galois LFSRs; LFSR k is seeded SEED ^ (k*32'h9E37_79B9), forced non-zero, and has an advance enable.

Verification
REQ-034 The bench SHALL preload addr 5 with 0x0000_0000, then request data 0xFFFF_FFFF, mask all ones, p_set=256 -> mem write 0xFFFF_FFFF at T+3, done_flips=32.
REQ-035 The bench SHALL preload addr 5 with 0xFFFF_FFFF, then request data 0, p_clr=0 -> write 0xFFFF_FFFF, done_flips=0.
REQ-036 The bench SHALL preload 0x0F0F_0F0F, then request data 0xF0F0_F0F0, mask 0x0000_FFFF, p_set=p_clr=256 -> write 0x0F0F_F0F0, done_flips=16.
REQ-037 The bench SHALL request bypass with data 0x1234_5678 at addr 3 -> single write at T+1, no read, done_flips=0, req_ready high at T+2.
REQ-038 The bench SHALL assert reset during CALC -> no write, no done_valid, req_ready=1 next cycle, RAM contents unchanged.
REQ-039 The bench SHALL preload stat_flips to 0xFFFF_FFF0, then complete an op with 32 flips -> stat_flips=0xFFFF_FFFF; stat_clear coincident with done -> stat_flips=0.
